// File: rtl/fetch_unit.sv
// IF stage of the pipelined MIPS core: PC/nPC with a branch delay slot,
// instruction-memory addressing and the IF/ID register. A redirect that
// arrives while stalled is latched and applied on the first free edge.
module fetch_unit #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  input  logic [31:0]       imem_instr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       pc_out,
  output logic [31:0]       npc_out,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic              redirect_pending
);

  typedef enum logic {RUN, PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] ifi_q, ifi_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        ifv_q, ifv_d;
  logic [31:0] redir_tgt;
  logic [31:0] next_tgt;

  // Targets are word-aligned; the low two bits of a redirect are dropped.
  assign redir_tgt = {redirect_target[31:2], 2'b00};

  // Next fetch target: a live redirect beats a latched one, else sequential.
  always_comb begin
    next_tgt = npc_q + 32'd4;
    if (redirect)             next_tgt = redir_tgt;
    else if (state_q == PEND) next_tgt = pend_q;
  end

  // Next-state logic for PC/nPC, IF/ID and the pending-redirect FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    pend_d  = pend_q;
    ifi_d   = ifi_q;
    ifpc_d  = ifpc_q;
    ifv_d   = ifv_q;
    if (!stall) begin
      // The old nPC is always fetched next, which gives the delay slot.
      pc_d    = npc_q;
      npc_d   = next_tgt;
      state_d = RUN;
      ifi_d   = imem_instr;
      ifpc_d  = pc_q;
      ifv_d   = 1'b1;
    end else if (redirect) begin
      // Newest redirect wins over any older pending target.
      pend_d  = redir_tgt;
      state_d = PEND;
    end
    // A flush bubbles IF/ID even when stalled; PC/nPC still follow stall.
    if (flush) begin
      ifi_d  = 32'h0;
      ifpc_d = 32'h0;
      ifv_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      pend_q  <= 32'h0;
      ifi_q   <= 32'h0;
      ifpc_q  <= 32'h0;
      ifv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      pend_q  <= pend_d;
      ifi_q   <= ifi_d;
      ifpc_q  <= ifpc_d;
      ifv_q   <= ifv_d;
    end
  end

  // Memory is addressed straight from the PC; upper bits alias.
  assign imem_addr        = pc_q[ADDR_W-1:0];
  assign pc_out           = pc_q;
  assign npc_out          = npc_q;
  assign if_id_instr      = ifi_q;
  assign if_id_pc         = ifpc_q;
  assign if_id_valid      = ifv_q;
  assign redirect_pending = (state_q == PEND);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each step drives one cycle of inputs,
// queues the expected post-edge state and compares it after the edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_instr;
  logic [8:0]  imem_addr;
  logic [31:0] pc_out, npc_out, if_id_instr, if_id_pc;
  logic        if_id_valid, redirect_pending;

  typedef struct {
    logic [31:0] pc, npc, ifpc, instr;
    logic        valid, pend;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntotal = 0;

  fetch_unit #(.ADDR_W(9), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_instr(imem_instr), .imem_addr(imem_addr),
    .pc_out(pc_out), .npc_out(npc_out), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word tagged with its own address.
  assign imem_instr = 32'hC0DE_0000 | {23'h0, imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive inputs, push expectation, compare after the edge.
  task automatic step(input logic rst_n, input logic st, input logic fl,
                      input logic rd, input logic [31:0] tgt,
                      input logic [31:0] epc, input logic [31:0] enpc,
                      input logic [31:0] eifpc, input logic ev, input logic ep);
    exp_t e;
    logic [31:0] a;
    reset = rst_n; stall = st; flush = fl; redirect = rd; redirect_target = tgt;
    a = eifpc;
    e.pc = epc; e.npc = enpc; e.ifpc = eifpc; e.valid = ev; e.pend = ep;
    e.instr = ev ? (32'hC0DE_0000 | {23'h0, a[8:0]}) : 32'h0;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check("pc_out",   pc_out,   e.pc);
    check("npc_out",  npc_out,  e.npc);
    check("if_id_pc", if_id_pc, e.ifpc);
    check("if_id_instr", if_id_instr, e.instr);
    check("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
    check("redirect_pending", {31'h0, redirect_pending}, {31'h0, e.pend});
    a = e.pc;
    check("imem_addr", {23'h0, imem_addr}, {23'h0, a[8:0]});
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    // Reset for two edges, then free-run
    step(0,0,0,0,0,        32'h0,  32'h4,  32'h0, 0,0);
    step(0,0,0,0,0,        32'h0,  32'h4,  32'h0, 0,0);
    step(1,0,0,0,0,        32'h4,  32'h8,  32'h0, 1,0);
    step(1,0,0,0,0,        32'h8,  32'hC,  32'h4, 1,0);
    step(1,0,0,0,0,        32'hC,  32'h10, 32'h8, 1,0);
    // Stall holds everything
    step(1,1,0,0,0,        32'hC,  32'h10, 32'h8, 1,0);
    step(1,1,0,0,0,        32'hC,  32'h10, 32'h8, 1,0);
    step(1,0,0,0,0,        32'h10, 32'h14, 32'hC, 1,0);
    // Redirect with delay slot, unaligned target
    step(1,0,0,1,32'h43,   32'h14, 32'h40, 32'h10, 1,0);
    step(1,0,0,0,0,        32'h40, 32'h44, 32'h14, 1,0);
    step(1,0,0,0,0,        32'h44, 32'h48, 32'h40, 1,0);
    // Redirects while stalled: latest pending target wins
    step(1,1,0,1,32'h80,   32'h44, 32'h48, 32'h40, 1,1);
    step(1,1,0,1,32'hA0,   32'h44, 32'h48, 32'h40, 1,1);
    step(1,0,0,0,0,        32'h48, 32'hA0, 32'h44, 1,0);
    step(1,0,0,0,0,        32'hA0, 32'hA4, 32'h48, 1,0);
    // Live redirect on release overrides the pending one
    step(1,1,0,1,32'h100,  32'hA0, 32'hA4, 32'h48, 1,1);
    step(1,0,0,1,32'h200,  32'hA4, 32'h200, 32'hA0, 1,0);
    step(1,0,0,0,0,        32'h200, 32'h204, 32'hA4, 1,0);
    // Flush with and without stall; then aliased fetch above ADDR_W
    step(1,1,1,0,0,        32'h200, 32'h204, 32'h0, 0,0);
    step(1,0,1,0,0,        32'h204, 32'h208, 32'h0, 0,0);
    step(1,0,0,0,0,        32'h208, 32'h20C, 32'h204, 1,0);
    // Address wrap at 2^32
    step(1,0,0,1,32'hFFFF_FFFF, 32'h20C, 32'hFFFF_FFFC, 32'h208, 1,0);
    step(1,0,0,0,0,        32'hFFFF_FFFC, 32'h0, 32'h20C, 1,0);
    step(1,0,0,0,0,        32'h0,  32'h4,  32'hFFFF_FFFC, 1,0);
    step(1,0,0,0,0,        32'h4,  32'h8,  32'h0, 1,0);
    // Reset while pending: pending target is discarded
    step(1,1,0,1,32'h300,  32'h4,  32'h8,  32'h0, 1,1);
    step(0,1,0,0,0,        32'h0,  32'h4,  32'h0, 0,0);
    step(1,0,0,0,0,        32'h4,  32'h8,  32'h0, 1,0);
    step(1,0,0,0,0,        32'h8,  32'hC,  32'h4, 1,0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
